timer_sequencer: RTL

AXI4-Lite master that programs, runs and stops one timer peripheral (register map PRE 0x00, ARE 0x04, CLR 0x08, ENA 0x0C, MOD 0x10, EVN 0x18, EVC 0x1C).
On start it writes the configuration, clears counter and event count, enables the timer, polls EVN until a target event count is reached, then disables the timer and reports done.

---
 rtl/timer_sequencer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/timer_sequencer.sv
// timer_sequencer: AXI4-Lite master that configures, runs and stops
// a timer peripheral, polling its event count until a target is hit.
module timer_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_GAP  = 16
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_pre,
  input  logic [31:0] cfg_are,
  input  logic        cfg_mode,
  input  logic [31:0] cfg_target,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam logic [31:0] OFF_PRE = 32'h00;
  localparam logic [31:0] OFF_ARE = 32'h04;
  localparam logic [31:0] OFF_CLR = 32'h08;
  localparam logic [31:0] OFF_ENA = 32'h0C;
  localparam logic [31:0] OFF_MOD = 32'h10;
  localparam logic [31:0] OFF_EVN = 32'h18;
  localparam logic [31:0] OFF_EVC = 32'h1C;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_ENA0,
    S_W_PRE,
    S_W_ARE,
    S_W_MOD,
    S_W_CLR,
    S_W_EVC,
    S_W_ENA1,
    S_POLL_WAIT,
    S_POLL_RD,
    S_W_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pre_q, pre_d;
  logic [31:0] are_q, are_d;
  logic        mode_q, mode_d;
  logic [31:0] target_q, target_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] araddr_q, araddr_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // Register offset targeted by each write state.
  function automatic logic [31:0] reg_off(state_t s);
    logic [31:0] o;
    o = OFF_ENA;
    unique case (s)
      S_W_PRE: o = OFF_PRE;
      S_W_ARE: o = OFF_ARE;
      S_W_MOD: o = OFF_MOD;
      S_W_CLR: o = OFF_CLR;
      S_W_EVC: o = OFF_EVC;
      default: o = OFF_ENA;
    endcase
    return o;
  endfunction

  // Successor of each write state in the programming sequence.
  function automatic state_t next_wr(state_t s);
    state_t n;
    n = S_W_STOP;
    unique case (s)
      S_W_ENA0: n = S_W_PRE;
      S_W_PRE:  n = S_W_ARE;
      S_W_ARE:  n = S_W_MOD;
      S_W_MOD:  n = S_W_CLR;
      S_W_CLR:  n = S_W_EVC;
      S_W_EVC:  n = S_W_ENA1;
      S_W_ENA1: n = S_POLL_WAIT;
      default:  n = S_W_STOP;
    endcase
    return n;
  endfunction

  // Next-state, handshake and state-entry output logic.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    are_d     = are_q;
    mode_d    = mode_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    error_d   = error_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pre_d    = cfg_pre;
          are_d    = cfg_are;
          mode_d   = cfg_mode;
          target_d = cfg_target;
          error_d  = 1'b0;
          state_d  = S_W_ENA0;
        end
      end
      S_POLL_WAIT: begin
        if (abort) begin
          state_d = S_W_STOP;
        end else if (cnt_q <= 32'd1) begin
          state_d = S_POLL_RD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_POLL_RD: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (rready_q && m_axi_rvalid) begin
          rready_d = 1'b0;
          if (m_axi_rresp != RESP_OKAY) begin
            error_d = 1'b1;
            state_d = S_W_STOP;
          end else if (abort || m_axi_rdata >= target_q) begin
            state_d = S_W_STOP;
          end else begin
            state_d = S_POLL_WAIT;
          end
        end
      end
      default: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) bready_d = 1'b1;
        if (bready_q && m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != RESP_OKAY) begin
            error_d = 1'b1;
            state_d = (state_q == S_W_STOP) ? S_IDLE : S_W_STOP;
          end else if (state_q == S_W_STOP) begin
            state_d = S_IDLE;
          end else if (abort) begin
            state_d = S_W_STOP;
          end else begin
            state_d = next_wr(state_q);
          end
        end
      end
    endcase

    if (state_d != state_q) begin
      unique case (state_d)
        S_IDLE: done_d = 1'b1;
        S_POLL_WAIT: cnt_d = 32'(POLL_GAP);
        S_POLL_RD: begin
          arvalid_d = 1'b1;
          araddr_d  = BASE_ADDR + OFF_EVN;
        end
        default: begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = BASE_ADDR + reg_off(state_d);
          unique case (state_d)
            S_W_PRE: wdata_d = pre_d;
            S_W_ARE: wdata_d = are_d;
            S_W_MOD: wdata_d = {31'd0, mode_d};
            S_W_CLR: wdata_d = 32'd1;
            S_W_EVC: wdata_d = 32'd1;
            S_W_ENA1: wdata_d = 32'd1;
            default: wdata_d = 32'd0;
          endcase
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      are_q     <= '0;
      mode_q    <= 1'b0;
      target_q  <= '0;
      cnt_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      are_q     <= are_d;
      mode_q    <= mode_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
